top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameters: none; all memory sizes are fixed by this document.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 WriteData  output  32  rs2 register value presented to data memory by the current instruction.
REQ-005 DataAdr  output  32  ALU result, used as the data memory byte address.
REQ-006 MemWrite  output  1  high when the current instruction is a store (sw).

Function
REQ-007 top SHALL be a single-cycle RV32I processor: one instruction fetched, executed and retired per clk cycle.
REQ-008 Instruction ROM SHALL be instance "imem" containing array "l_rom", 64 x 32-bit words.
  - Read combinationally at PC[7:2].
  - No internal initialisation; loaded externally via $readmemh through hierarchical path imem.l_rom.
REQ-009 Data RAM SHALL be 64 x 32-bit words.
  - Word-addressed by DataAdr[7:2].
  - Combinational read.
  - Write of WriteData on rising clk when MemWrite=1.
  - Not cleared by reset.
REQ-010 Register file SHALL have 32 x 32 bits, two combinational read ports and one write port on rising clk; x0 reads 0 and ignores writes.
REQ-011 Supported instructions SHALL be lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal; any other opcode writes nothing (RegWrite=0, MemWrite=0) and advances PC by 4.
REQ-012 Immediates SHALL be sign-extended per format: I (instr[31:20]), S ({instr[31:25],instr[11:7]}), B (13-bit, LSB 0), J (21-bit, LSB 0).
REQ-013 ALU SHALL be 32-bit, wrap-around add/sub (no overflow trap), and, or, and signed slt producing 0 or 1; Zero flag = (result==0).
REQ-014 ALU control:
  - sub for beq.
  - For R-type: sub when funct3=000 and funct7[5]=1; otherwise funct3 selects add(000)/slt(010)/or(110)/and(111).
  - addi/slti/ori/andi use the same funct3 decode, always add for funct3=000.
  - lw/sw use add.
REQ-015 Next PC SHALL be:
  - PC+imm for jal;
  - PC+imm for beq when Zero=1;
  - otherwise PC+4.
  - PC wraps modulo 2^32.
REQ-016 Register writeback source SHALL be:
  - read data for lw;
  - PC+4 for jal;
  - ALU result otherwise.
  - No writeback for sw and beq.
REQ-017 WriteData, DataAdr and MemWrite SHALL be combinational functions of the current PC and architectural state, valid before each rising clk.
REQ-018 An instruction that reads and writes the same register SHALL read the old value; the new value is visible next cycle.

Reset
REQ-019 While reset=0:
  - PC SHALL be 0 immediately (asynchronous) and held.
  - All registers x1-x31 SHALL be cleared.
  - MemWrite SHALL be forced to 0.
  - Register file and data RAM writes SHALL be suppressed.
REQ-020 On reset deassertion, the first rising clk SHALL execute the instruction at address 0.
REQ-021 Reset asserted mid-program SHALL abort execution at once; after release, execution restarts from address 0.
REQ-022 DataAdr/WriteData during reset SHALL reflect the decode of imem word 0 with cleared registers.

Verification
REQ-023 Standard RV32I test program (addi/or/and/add/beq/slt/sub/sw/lw/jal sequence) loaded into imem.l_rom, reset low for 1 time unit then released:
  - first store SHALL be DataAdr=96, WriteData=7;
  - final store SHALL be DataAdr=100, WriteData=25;
  - no store SHALL go to any other address.
REQ-024 addi x5,x0,-1 then sw x5,4(x0) -> MemWrite=1, DataAdr=4, WriteData=0xFFFFFFFF.
REQ-025 addi x1,x0,5; addi x2,x0,5; beq x1,x2,+8 -> the instruction at +4 is skipped; PC goes 8 -> 16.
REQ-026 jal x1,+12 at PC=0 -> x1=4, next PC=12; addi x0,x0,9 then sw x0,0(x0) -> WriteData=0.
REQ-027 Reset asserted mid-program -> PC=0 and MemWrite=0 without waiting for a clock edge; after release, the first-cycle outputs match a fresh start.
REQ-028 slti x3,x0,-1 -> x3=0; slt with -1 < 1 -> 1; add 0x7FFFFFFF+1 -> 0x80000000.

Source files
------------

// File: rtl/top.sv
// Single-cycle RV32I subset core (lw/sw/add/sub/and/or/slt/addi/andi/ori/slti/beq/jal)
// with a 64-word instruction ROM and a 64-word data RAM.
module imem (
  input  logic [5:0]  i_addr,
  output logic [31:0] o_rd
);
  logic [31:0] l_rom [0:63];

  // Contents are loaded from outside through imem.l_rom.
  assign o_rd = l_rom[i_addr];
endmodule

module top (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [31:0] r_pc;
  logic [31:0] r_rf   [0:31];
  logic [31:0] r_dmem [0:63];

  logic [31:0] w_instr, w_imm, w_rs1, w_rs2, w_src_b, w_alu;
  logic [31:0] w_rdata, w_result, w_pc4, w_pc_target, w_pc_next;
  logic [6:0]  w_op;
  logic [2:0]  w_f3, w_alu_ctl;
  logic [4:0]  w_rd, w_ra1, w_ra2;
  logic        w_is_lw, w_is_sw, w_is_r, w_is_i, w_is_br, w_is_jal;
  logic        w_reg_write, w_mem_write, w_zero, w_take;

  imem imem (
    .i_addr (r_pc[7:2]),
    .o_rd   (w_instr)
  );

  assign w_op  = w_instr[6:0];
  assign w_f3  = w_instr[14:12];
  assign w_rd  = w_instr[11:7];
  assign w_ra1 = w_instr[19:15];
  assign w_ra2 = w_instr[24:20];

  assign w_is_lw  = (w_op == OP_LW);
  assign w_is_sw  = (w_op == OP_SW);
  assign w_is_r   = (w_op == OP_R);
  assign w_is_i   = (w_op == OP_I);
  assign w_is_br  = (w_op == OP_BR) && (w_f3 == 3'b000);
  assign w_is_jal = (w_op == OP_JAL);

  assign w_reg_write = w_is_lw | w_is_r | w_is_i | w_is_jal;
  // Gating with reset keeps the RAM write suppressed and the port low while reset is held.
  assign w_mem_write = w_is_sw & reset;

  always_comb begin
    w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
    if (w_is_sw)
      w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    else if (w_is_br)
      w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    else if (w_is_jal)
      w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
  end

  assign w_rs1   = (w_ra1 == 5'd0) ? 32'd0 : r_rf[w_ra1];
  assign w_rs2   = (w_ra2 == 5'd0) ? 32'd0 : r_rf[w_ra2];
  assign w_src_b = (w_is_r | w_is_br) ? w_rs2 : w_imm;

  // Only R-type may select sub through funct7; immediate forms always add on funct3=000.
  always_comb begin
    w_alu_ctl = ALU_ADD;
    if (w_is_br) begin
      w_alu_ctl = ALU_SUB;
    end else if (w_is_r || w_is_i) begin
      case (w_f3)
        3'b000:  w_alu_ctl = (w_is_r && w_instr[30]) ? ALU_SUB : ALU_ADD;
        3'b010:  w_alu_ctl = ALU_SLT;
        3'b110:  w_alu_ctl = ALU_OR;
        3'b111:  w_alu_ctl = ALU_AND;
        default: w_alu_ctl = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    case (w_alu_ctl)
      ALU_SUB: w_alu = w_rs1 - w_src_b;
      ALU_AND: w_alu = w_rs1 & w_src_b;
      ALU_OR:  w_alu = w_rs1 | w_src_b;
      ALU_SLT: w_alu = {31'd0, $signed(w_rs1) < $signed(w_src_b)};
      default: w_alu = w_rs1 + w_src_b;
    endcase
  end

  assign w_zero      = (w_alu == 32'd0);
  assign w_rdata     = r_dmem[w_alu[7:2]];
  assign w_pc4       = r_pc + 32'd4;
  assign w_pc_target = r_pc + w_imm;
  assign w_take      = w_is_jal | (w_is_br & w_zero);
  assign w_pc_next   = w_take ? w_pc_target : w_pc4;
  assign w_result    = w_is_lw ? w_rdata : (w_is_jal ? w_pc4 : w_alu);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pc <= 32'd0;
    else        r_pc <= w_pc_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_reg_write && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_write) r_dmem[w_alu[7:2]] <= w_rs2;
  end

  assign DataAdr   = w_alu;
  assign WriteData = w_rs2;
  assign MemWrite  = w_mem_write;
endmodule

// File: tb/tb_top.sv
// Directed bench for the single-cycle core: small hand-assembled programs,
// stores observed on the data-memory port and checked against hand-computed values.
module tb_top;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] WriteData, DataAdr;
  logic        MemWrite;
  int          checks = 0;
  int          errors = 0;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;

  top dut (
    .clk       (clk),
    .reset     (reset),
    .WriteData (WriteData),
    .DataAdr   (DataAdr),
    .MemWrite  (MemWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [2:0] f3, input logic [31:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [2:0] f3,
                                        input logic [31:0] rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic hold_reset;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) dut.imem.l_rom[i] = 32'h0000_0013;
  endtask

  task automatic release_reset;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_std;
    logic [31:0] prog [21];
    prog = '{32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
             32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463, 32'h00000293,
             32'h0023A233, 32'h005203B3, 32'h402383B3, 32'h0471AA23, 32'h06002103,
             32'h005104B3, 32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
             32'h00210063};
    for (int i = 0; i < 21; i++) dut.imem.l_rom[i] = prog[i];
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) dut.imem.l_rom[i] = 32'h0000_0013;
    dut.imem.l_rom[0] = enc_s(8, 5, 0);
    #2;
    $display("reset: pc=%0d memwrite=%0b adr=%0d wd=%0d", dut.r_pc, MemWrite, DataAdr, WriteData);
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite: got %b expected 0", MemWrite); end
    checks++; if (dut.r_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", dut.r_pc); end
    checks++; if (DataAdr !== 32'd8) begin errors++; $display("FAIL reset_dataadr: got %h expected 8", DataAdr); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL reset_writedata: got %h expected 0", WriteData); end
    @(negedge clk);
    checks++; if (dut.r_pc !== 32'd0) begin errors++; $display("FAIL reset_pc_held: got %h expected 0", dut.r_pc); end
  endtask

  task automatic test_std_program;
    int n = 0;
    logic [31:0] fa = '0, fd = '0, la = '0, ld = '0;
    hold_reset();
    load_std();
    #1 reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (MemWrite === 1'b1) begin
        $display("std store %0d: adr=%0d data=%0d", n, DataAdr, WriteData);
        checks++;
        if (DataAdr !== 32'd96 && DataAdr !== 32'd100) begin
          errors++; $display("FAIL std_store_addr: got %0d expected 96 or 100", DataAdr);
        end
        if (n == 0) begin fa = DataAdr; fd = WriteData; end
        la = DataAdr; ld = WriteData; n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL std_store_count: got %0d expected 2", n); end
    checks++; if (fa !== 32'd96) begin errors++; $display("FAIL std_first_adr: got %0d expected 96", fa); end
    checks++; if (fd !== 32'd7) begin errors++; $display("FAIL std_first_data: got %0d expected 7", fd); end
    checks++; if (la !== 32'd100) begin errors++; $display("FAIL std_last_adr: got %0d expected 100", la); end
    checks++; if (ld !== 32'd25) begin errors++; $display("FAIL std_last_data: got %0d expected 25", ld); end
  endtask

  task automatic test_mid_reset;
    bit found = 0;
    hold_reset();
    load_std();
    release_reset();
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (MemWrite === 1'b1) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_wait_store: got no store within 30 cycles expected one"); end
    #2 reset = 1'b0;
    #1;
    $display("mid reset: pc=%0d memwrite=%0b adr=%0d wd=%0d", dut.r_pc, MemWrite, DataAdr, WriteData);
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL mid_memwrite: got %b expected 0", MemWrite); end
    checks++; if (dut.r_pc !== 32'd0) begin errors++; $display("FAIL mid_pc: got %h expected 0", dut.r_pc); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL mid_writedata: got %h expected 0", WriteData); end
    release_reset();
    #1;
    checks++; if (DataAdr !== 32'd5) begin errors++; $display("FAIL mid_restart_adr: got %h expected 5", DataAdr); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL mid_restart_wd: got %h expected 0", WriteData); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL mid_restart_mw: got %b expected 0", MemWrite); end
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (MemWrite === 1'b1) begin
        found = 1;
        $display("mid restart store: adr=%0d data=%0d", DataAdr, WriteData);
        checks++; if (DataAdr !== 32'd96) begin errors++; $display("FAIL mid_store_adr: got %0d expected 96", DataAdr); end
        checks++; if (WriteData !== 32'd7) begin errors++; $display("FAIL mid_store_data: got %0d expected 7", WriteData); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_restart_store: got none expected one"); end
  endtask

  task automatic test_sw_neg;
    hold_reset();
    dut.imem.l_rom[0] = enc_i(-1, 0, 3'b000, 5, OP_I);
    dut.imem.l_rom[1] = enc_s(4, 5, 0);
    release_reset();
    #1;
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL swneg_addi_mw: got %b expected 0", MemWrite); end
    @(negedge clk);
    $display("sw_neg: memwrite=%0b adr=%0d wd=%h", MemWrite, DataAdr, WriteData);
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL swneg_mw: got %b expected 1", MemWrite); end
    checks++; if (DataAdr !== 32'd4) begin errors++; $display("FAIL swneg_adr: got %h expected 4", DataAdr); end
    checks++; if (WriteData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL swneg_wd: got %h expected ffffffff", WriteData); end
  endtask

  task automatic test_beq;
    hold_reset();
    dut.imem.l_rom[0] = enc_i(5, 0, 3'b000, 1, OP_I);
    dut.imem.l_rom[1] = enc_i(5, 0, 3'b000, 2, OP_I);
    dut.imem.l_rom[2] = enc_b(8, 2, 1);
    dut.imem.l_rom[3] = enc_i(1, 0, 3'b000, 3, OP_I);
    dut.imem.l_rom[4] = enc_s(0, 3, 0);
    release_reset();
    repeat (3) @(negedge clk);
    $display("beq: pc=%0d memwrite=%0b adr=%0d wd=%0d", dut.r_pc, MemWrite, DataAdr, WriteData);
    checks++; if (dut.r_pc !== 32'd16) begin errors++; $display("FAIL beq_pc: got %0d expected 16", dut.r_pc); end
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL beq_mw: got %b expected 1", MemWrite); end
    checks++; if (DataAdr !== 32'd0) begin errors++; $display("FAIL beq_adr: got %h expected 0", DataAdr); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL beq_skip_wd: got %h expected 0", WriteData); end
  endtask

  task automatic test_jal;
    hold_reset();
    dut.imem.l_rom[0] = enc_j(12, 1);
    dut.imem.l_rom[1] = enc_i(99, 0, 3'b000, 1, OP_I);
    dut.imem.l_rom[2] = enc_i(99, 0, 3'b000, 1, OP_I);
    dut.imem.l_rom[3] = enc_s(8, 1, 0);
    dut.imem.l_rom[4] = enc_i(9, 0, 3'b000, 0, OP_I);
    dut.imem.l_rom[5] = enc_s(0, 0, 0);
    release_reset();
    @(negedge clk);
    $display("jal: pc=%0d memwrite=%0b adr=%0d wd=%0d", dut.r_pc, MemWrite, DataAdr, WriteData);
    checks++; if (dut.r_pc !== 32'd12) begin errors++; $display("FAIL jal_pc: got %0d expected 12", dut.r_pc); end
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL jal_mw: got %b expected 1", MemWrite); end
    checks++; if (DataAdr !== 32'd8) begin errors++; $display("FAIL jal_adr: got %h expected 8", DataAdr); end
    checks++; if (WriteData !== 32'd4) begin errors++; $display("FAIL jal_link: got %h expected 4", WriteData); end
    repeat (2) @(negedge clk);
    $display("x0 store: memwrite=%0b adr=%0d wd=%0d", MemWrite, DataAdr, WriteData);
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL x0_mw: got %b expected 1", MemWrite); end
    checks++; if (DataAdr !== 32'd0) begin errors++; $display("FAIL x0_adr: got %h expected 0", DataAdr); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL x0_wd: got %h expected 0", WriteData); end
  endtask

  task automatic test_alu;
    logic [31:0] exp_a [6];
    logic [31:0] exp_d [6];
    int n = 0;
    exp_a = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
    exp_d = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFE, 32'd3, 32'h8000_0000};
    hold_reset();
    dut.imem.l_rom[0] = enc_i(7, 0, 3'b000, 3, OP_I);
    dut.imem.l_rom[1] = enc_i(-1, 0, 3'b010, 3, OP_I);
    dut.imem.l_rom[2] = enc_s(0, 3, 0);
    dut.imem.l_rom[3] = enc_i(-1, 0, 3'b000, 1, OP_I);
    dut.imem.l_rom[4] = enc_i(1, 0, 3'b000, 2, OP_I);
    dut.imem.l_rom[5] = enc_r(7'd0, 2, 1, 3'b010, 4);
    dut.imem.l_rom[6] = enc_s(4, 4, 0);
    dut.imem.l_rom[7] = enc_i(-2048, 0, 3'b000, 6, OP_I);
    for (int i = 8; i < 28; i++) dut.imem.l_rom[i] = enc_r(7'd0, 6, 6, 3'b000, 6);
    dut.imem.l_rom[28] = enc_r(7'd0, 1, 6, 3'b000, 6);
    dut.imem.l_rom[29] = enc_r(7'd0, 2, 6, 3'b000, 7);
    dut.imem.l_rom[30] = enc_s(8, 7, 0);
    dut.imem.l_rom[31] = enc_r(7'b0100000, 2, 1, 3'b000, 8);
    dut.imem.l_rom[32] = enc_s(12, 8, 0);
    dut.imem.l_rom[33] = enc_i(6, 2, 3'b110, 10, OP_I);
    dut.imem.l_rom[34] = enc_i(3, 10, 3'b111, 11, OP_I);
    dut.imem.l_rom[35] = enc_s(16, 11, 0);
    dut.imem.l_rom[36] = enc_i(8, 0, 3'b010, 12, OP_LW);
    dut.imem.l_rom[37] = enc_s(20, 12, 0);
    release_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (MemWrite === 1'b1) begin
        $display("alu store %0d: adr=%0d data=%h", n, DataAdr, WriteData);
        if (n < 6) begin
          checks++; if (DataAdr !== exp_a[n]) begin errors++; $display("FAIL alu_adr_%0d: got %0d expected %0d", n, DataAdr, exp_a[n]); end
          checks++; if (WriteData !== exp_d[n]) begin errors++; $display("FAIL alu_data_%0d: got %h expected %h", n, WriteData, exp_d[n]); end
        end
        n++;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL alu_store_count: got %0d expected 6", n); end
  endtask

  initial begin
    test_reset();
    test_std_program();
    test_mid_reset();
    test_sw_neg();
    test_beq();
    test_jal();
    test_alu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
